// File: rtl/cla5_rr_scheduler.sv
// rtl/cla5_rr_scheduler.sv - round-robin sharing of one pipelined 5-bit adder between two requesters
//
// Purpose
//   Two client datapaths submit add/sub ops on valid/ready ports. At most one op
//   per cycle is issued to an external pipelined adder of latency LAT. Each issued
//   op is tagged with its requester id. The result is registered and returned as a
//   one-cycle pulse on that requester's response port, LAT+1 cycles after issue.
//
// Ports
//   clk, rst_n                         clock, asynchronous active-low reset
//   req{0,1}_valid / req{0,1}_ready    op handshake (ready is combinational grant)
//   req{0,1}_a, _b, _cin, _sub         operands; sub=1 computes a-b, cin ignored
//   add_a, add_b, add_cin              drive to adder in the issue cycle, else 0
//   add_s, add_cout                    adder result, valid LAT cycles after issue
//   rsp{0,1}_valid, _s, _cout          registered result pulse per requester

module cla5_rr_scheduler #(
   parameter int LAT = 2
) (
   input  logic       clk,
   input  logic       rst_n,

   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [4:0] req0_a,
   input  logic [4:0] req0_b,
   input  logic       req0_cin,
   input  logic       req0_sub,

   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic [4:0] req1_a,
   input  logic [4:0] req1_b,
   input  logic       req1_cin,
   input  logic       req1_sub,

   output logic [4:0] add_a,
   output logic [4:0] add_b,
   output logic       add_cin,
   input  logic [4:0] add_s,
   input  logic       add_cout,

   output logic       rsp0_valid,
   output logic [4:0] rsp0_s,
   output logic       rsp0_cout,

   output logic       rsp1_valid,
   output logic [4:0] rsp1_s,
   output logic       rsp1_cout
);

   // Requester that wins a tie next time both are valid.
   logic prio;

   // Grant decision for the current cycle.
   logic issue;
   logic gnt_id;

   // Operands of the granted requester.
   logic [4:0] sel_a;
   logic [4:0] sel_b;
   logic       sel_cin;
   logic       sel_sub;

   // Tag pipeline: bit i holds the op issued i+1 cycles ago.
   logic [LAT-1:0] tag_vld;
   logic [LAT-1:0] tag_id;

   logic out_vld;
   logic out_id;

   // ------------------------------------------------------------------
   // Arbitration. Outputs are forced quiet while reset is asserted so that
   // nothing is granted and the adder sees zeros.
   // ------------------------------------------------------------------
   always_comb begin
      issue  = 1'b0;
      gnt_id = 1'b0;
      if (rst_n) begin
         if (req0_valid && req1_valid) begin
            issue  = 1'b1;
            gnt_id = prio;
         end else if (req0_valid) begin
            issue  = 1'b1;
            gnt_id = 1'b0;
         end else if (req1_valid) begin
            issue  = 1'b1;
            gnt_id = 1'b1;
         end
      end
   end

   assign req0_ready = issue & ~gnt_id;
   assign req1_ready = issue &  gnt_id;

   // ------------------------------------------------------------------
   // Issue drive. Subtraction is a + ~b + 1, so the requester's cin is
   // replaced by 1 and add_cout becomes the not-borrow flag.
   // ------------------------------------------------------------------
   always_comb begin
      sel_a   = gnt_id ? req1_a   : req0_a;
      sel_b   = gnt_id ? req1_b   : req0_b;
      sel_cin = gnt_id ? req1_cin : req0_cin;
      sel_sub = gnt_id ? req1_sub : req0_sub;
   end

   always_comb begin
      add_a   = 5'd0;
      add_b   = 5'd0;
      add_cin = 1'b0;
      if (issue) begin
         add_a   = sel_a;
         add_b   = sel_sub ? ~sel_b : sel_b;
         add_cin = sel_sub | sel_cin;
      end
   end

   // ------------------------------------------------------------------
   // Round-robin pointer: after an issue, the other requester wins ties.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio <= 1'b0;
      end else if (issue) begin
         prio <= ~gnt_id;
      end
   end

   // ------------------------------------------------------------------
   // Tag pipeline tracks which requester owns the adder result that appears
   // LAT cycles after issue. Clearing it on reset discards in-flight ops even
   // though the adder itself keeps its data.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_vld <= '0;
         tag_id  <= '0;
      end else begin
         tag_vld[0] <= issue;
         tag_id[0]  <= gnt_id;
         for (int i = 1; i < LAT; i++) begin
            tag_vld[i] <= tag_vld[i-1];
            tag_id[i]  <= tag_id[i-1];
         end
      end
   end

   assign out_vld = tag_vld[LAT-1];
   assign out_id  = tag_id[LAT-1];

   // ------------------------------------------------------------------
   // Response registers. The port not addressed keeps its last data.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp0_valid <= 1'b0;
         rsp0_s     <= 5'd0;
         rsp0_cout  <= 1'b0;
      end else begin
         rsp0_valid <= out_vld & ~out_id;
         if (out_vld && !out_id) begin
            rsp0_s    <= add_s;
            rsp0_cout <= add_cout;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp1_valid <= 1'b0;
         rsp1_s     <= 5'd0;
         rsp1_cout  <= 1'b0;
      end else begin
         rsp1_valid <= out_vld & out_id;
         if (out_vld && out_id) begin
            rsp1_s    <= add_s;
            rsp1_cout <= add_cout;
         end
      end
   end

endmodule

// File: tb/tb_cla5_rr_scheduler.sv
// tb/tb_cla5_rr_scheduler.sv - scoreboard bench for cla5_rr_scheduler

module tb_cla5_rr_scheduler;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req0_valid = 1'b0, req1_valid = 1'b0;
   logic       req0_ready, req1_ready;
   logic [4:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic       req0_cin = 1'b0, req0_sub = 1'b0, req1_cin = 1'b0, req1_sub = 1'b0;
   logic [4:0] add_a, add_b, add_s;
   logic       add_cin, add_cout;
   logic       rsp0_valid, rsp0_cout, rsp1_valid, rsp1_cout;
   logic [4:0] rsp0_s, rsp1_s;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   typedef struct {
      logic [5:0] d;
      int         due;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   cla5_rr_scheduler #(.LAT(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req0_cin(req0_cin), .req0_sub(req0_sub),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .req1_cin(req1_cin), .req1_sub(req1_sub),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s), .add_cout(add_cout),
      .rsp0_valid(rsp0_valid), .rsp0_s(rsp0_s), .rsp0_cout(rsp0_cout),
      .rsp1_valid(rsp1_valid), .rsp1_s(rsp1_s), .rsp1_cout(rsp1_cout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Adder model: registered inputs, registered outputs, no reset.
   logic [4:0] r_a = '0, r_b = '0;
   logic       r_c = 1'b0;
   always @(posedge clk) begin
      r_a <= add_a;
      r_b <= add_b;
      r_c <= add_cin;
      {add_cout, add_s} <= 6'(r_a) + 6'(r_b) + 6'(r_c);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pop and compare whenever a response pulse is presented.
   task automatic take_rsp(input int id, input logic [5:0] got);
      exp_t e;
      if (id == 0 && q0.size() == 0 || id == 1 && q1.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL rsp%0d_unexpected: got pulse data %0d expected no pulse (cycle %0d)", id, got, cyc);
      end else begin
         e = (id == 0) ? q0.pop_front() : q1.pop_front();
         chk($sformatf("rsp%0d_data", id), 32'(got), 32'(e.d));
         chk($sformatf("rsp%0d_cycle", id), cyc, e.due);
      end
   endtask

   always @(negedge clk) begin
      if (rsp0_valid === 1'b1) take_rsp(0, {rsp0_cout, rsp0_s});
      if (rsp1_valid === 1'b1) take_rsp(1, {rsp1_cout, rsp1_s});
   end

   // One cycle of stimulus; exp_g is the expected grant (-1 = none).
   task automatic drive(
      input logic v0, input logic [4:0] a0, input logic [4:0] b0, input logic c0, input logic s0,
      input logic v1, input logic [4:0] a1, input logic [4:0] b1, input logic c1, input logic s1,
      input int exp_g, input logic [4:0] e_a, input logic [4:0] e_b, input logic e_cin,
      input logic [4:0] e_s, input logic e_cout, input bit push, input string tag);
      exp_t e;
      @(negedge clk);
      req0_valid = v0; req0_a = a0; req0_b = b0; req0_cin = c0; req0_sub = s0;
      req1_valid = v1; req1_a = a1; req1_b = b1; req1_cin = c1; req1_sub = s1;
      #1;
      chk({tag, "_ready0"}, 32'(req0_ready), 32'(exp_g == 0));
      chk({tag, "_ready1"}, 32'(req1_ready), 32'(exp_g == 1));
      chk({tag, "_add_a"}, 32'(add_a), 32'(e_a));
      chk({tag, "_add_b"}, 32'(add_b), 32'(e_b));
      chk({tag, "_add_cin"}, 32'(add_cin), 32'(e_cin));
      if (push && exp_g >= 0) begin
         e.d   = {e_cout, e_s};
         e.due = cyc + 3;
         if (exp_g == 0) q0.push_back(e);
         else            q1.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         req0_valid = 1'b0;
         req1_valid = 1'b0;
      end
   endtask

   // Both-valid alternation table: operands change each cycle.
   logic [4:0] t_a0[6] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6};
   logic [4:0] t_b0[6] = '{5'd0, 5'd2, 5'd4, 5'd6, 5'd8, 5'd10};
   logic [4:0] t_b1[6] = '{5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9};
   int         t_g[6]  = '{0, 1, 0, 1, 0, 1};
   logic [4:0] t_ea[6] = '{5'd1, 5'd20, 5'd3, 5'd20, 5'd5, 5'd20};
   logic [4:0] t_eb[6] = '{5'd0, 5'd26, 5'd4, 5'd24, 5'd8, 5'd22};
   logic [4:0] t_es[6] = '{5'd2, 5'd15, 5'd8, 5'd13, 5'd14, 5'd11};
   logic       t_ec[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

   initial begin
      // 1: reset held, inputs toggling
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         req0_valid = 1'b1; req0_a = 5'(i * 7 + 3); req0_b = 5'(i + 11); req0_sub = i[0];
         req1_valid = i[1]; req1_a = 5'(31 - i); req1_b = 5'(i * 3); req1_cin = 1'b1;
         #1;
         chk("rst_ready0", 32'(req0_ready), 0);
         chk("rst_ready1", 32'(req1_ready), 0);
         chk("rst_add", 32'({add_a, add_b, add_cin}), 0);
         chk("rst_rsp", 32'({rsp0_valid, rsp0_s, rsp0_cout, rsp1_valid, rsp1_s, rsp1_cout}), 0);
      end
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      rst_n = 1'b1;

      // 2: req0 7+9
      drive(1, 5'd7, 5'd9, 0, 0,  0, 5'd0, 5'd0, 0, 0,  0, 5'd7, 5'd9, 0, 5'd16, 0, 1, "add7_9");
      idle(4);

      // 3: req1 3-5 then 5-3 back to back
      drive(0, 5'd0, 5'd0, 0, 0,  1, 5'd3, 5'd5, 0, 1,  1, 5'd3, 5'd26, 1, 5'd30, 0, 1, "sub3_5");
      drive(0, 5'd0, 5'd0, 0, 0,  1, 5'd5, 5'd3, 0, 1,  1, 5'd5, 5'd28, 1, 5'd2, 1, 1, "sub5_3");
      idle(4);

      // 4: wrap cases
      drive(1, 5'd31, 5'd0, 1, 0,  0, 5'd0, 5'd0, 0, 0,  0, 5'd31, 5'd0, 1, 5'd0, 1, 1, "add31_0_1");
      drive(0, 5'd0, 5'd0, 0, 0,  1, 5'd31, 5'd31, 1, 0,  1, 5'd31, 5'd31, 1, 5'd31, 1, 1, "add31_31_1");
      idle(5);

      // 5: both valid from reset, grants alternate
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 6; i++)
         drive(1, t_a0[i], t_b0[i], 1, 0,  1, 5'd20, t_b1[i], 0, 1,
               t_g[i], t_ea[i], t_eb[i], 1, t_es[i], t_ec[i], 1, $sformatf("alt%0d", i));
      idle(5);

      // 6: reset mid-flight discards the op and restores prio
      drive(1, 5'd4, 5'd4, 0, 0,  0, 5'd0, 5'd0, 0, 0,  0, 5'd4, 5'd4, 0, 5'd8, 0, 0, "flight");
      @(negedge clk); req0_valid = 1'b0; rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      idle(6);
      drive(1, 5'd2, 5'd3, 0, 0,  1, 5'd9, 5'd9, 0, 0,  0, 5'd2, 5'd3, 0, 5'd5, 0, 1, "prio_after_rst");
      idle(6);

      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
      $fatal(1);
   end

endmodule
